// File: rtl/alarm_pkg.sv
// Shared definitions for the frame-difference alarm path: detector FSM encoding
// and the default pixel geometry that the background BRAM instance must also use.
package alarm_pkg;

    localparam int unsigned ALARM_WIDTH = 11;
    localparam int unsigned ALARM_DEPTH = 320 * 240;

    // ST_WAIT is the "waiting for sof" phase after LEARN or after an evaluation.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEARN,
        ST_WAIT,
        ST_DETECT,
        ST_DRAIN,
        ST_EVAL
    } det_state_e;

endpackage

// File: rtl/abs_diff_cmp.sv
// Combinational |a - b| > THRESH on unsigned pixel intensities; the subtraction
// is ordered so the magnitude never wraps.
module abs_diff_cmp #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned THRESH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt
);

    logic [WIDTH-1:0] diff;

    always_comb begin
        diff = (a >= b) ? (a - b) : (b - a);
        gt   = (32'(diff) > THRESH);
    end

endmodule

// File: rtl/frame_diff_detector.sv
// Compares live pixels against a BRAM-held background, writes the live pixel back,
// counts changed pixels per frame and raises a sticky alarm past a count limit.
module frame_diff_detector
    import alarm_pkg::*;
#(
    parameter int unsigned WIDTH        = ALARM_WIDTH,
    parameter int unsigned DEPTH        = ALARM_DEPTH,
    parameter int unsigned PIX_THRESH   = 64,
    parameter int unsigned COUNT_THRESH = 1000,
    parameter int unsigned AW           = $clog2(DEPTH),
    parameter int unsigned CW           = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             alarm_ack,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [WIDTH-1:0] pix_data,
    output logic             bram_rd,
    output logic [AW-1:0]    bram_rd_addr,
    input  logic [WIDTH-1:0] bram_rd_data,
    output logic             bram_en,
    output logic             bram_wr,
    output logic [AW-1:0]    bram_wr_addr,
    output logic [WIDTH-1:0] bram_wr_data,
    output logic             alarm,
    output logic [CW-1:0]    changed_count,
    output logic             frame_done
);

    det_state_e       state_q;
    logic [AW-1:0]    addr_q, addr_d, idx;
    logic [CW-1:0]    accum_q, accum_d;
    logic             s1_valid_q, s1_cmp_q;
    logic [WIDTH-1:0] s1_pix_q;
    logic [AW-1:0]    s1_addr_q;
    logic             alarm_q, frame_done_q;
    logic [CW-1:0]    changed_q;
    logic             accept, cmp_en, last, changed, wr_block;

    abs_diff_cmp #(
        .WIDTH  (WIDTH),
        .THRESH (PIX_THRESH)
    ) u_cmp (
        .a  (s1_pix_q),
        .b  (bram_rd_data),
        .gt (changed)
    );

    always_comb begin
        accept = 1'b0;
        cmp_en = 1'b0;
        if (arm && pix_valid) begin
            case (state_q)
                ST_IDLE:   accept = pix_sof;
                ST_LEARN:  accept = 1'b1;
                ST_WAIT:   begin accept = pix_sof; cmp_en = 1'b1; end
                ST_DETECT: begin accept = 1'b1;    cmp_en = 1'b1; end
                default:   ;
            endcase
        end
        idx    = pix_sof ? '0 : addr_q;
        last   = (idx == AW'(DEPTH - 1));
        addr_d = last ? '0 : idx + 1'b1;
    end

    // A resync right after index 0 would read and write address 0 together;
    // the abandoned frame's write is the one dropped.
    assign wr_block     = bram_rd && s1_valid_q && (idx == s1_addr_q);
    assign bram_rd      = accept && cmp_en;
    assign bram_rd_addr = idx;
    assign bram_wr      = s1_valid_q && !wr_block;
    assign bram_en      = bram_wr;
    assign bram_wr_addr = s1_addr_q;
    assign bram_wr_data = s1_pix_q;

    always_comb begin
        accum_d = accum_q;
        if (!arm || state_q == ST_EVAL || (accept && pix_sof)) begin
            accum_d = '0;
        end else if (s1_valid_q && s1_cmp_q && changed && accum_q < CW'(DEPTH)) begin
            accum_d = accum_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            accum_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_cmp_q     <= 1'b0;
            s1_pix_q     <= '0;
            s1_addr_q    <= '0;
            alarm_q      <= 1'b0;
            frame_done_q <= 1'b0;
            changed_q    <= '0;
        end else begin
            frame_done_q <= 1'b0;
            s1_valid_q   <= accept;
            s1_cmp_q     <= cmp_en;
            accum_q      <= accum_d;
            if (accept) begin
                s1_pix_q  <= pix_data;
                s1_addr_q <= idx;
                addr_q    <= addr_d;
            end
            if (alarm_ack) begin
                alarm_q <= 1'b0;
            end
            if (!arm) begin
                state_q <= ST_IDLE;
                addr_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE:   if (accept) state_q <= last ? ST_WAIT : ST_LEARN;
                    ST_LEARN:  if (accept && last) state_q <= ST_WAIT;
                    ST_WAIT:   if (accept) state_q <= last ? ST_DRAIN : ST_DETECT;
                    ST_DETECT: if (accept && last) state_q <= ST_DRAIN;
                    ST_DRAIN:  state_q <= ST_EVAL;
                    ST_EVAL: begin
                        state_q      <= ST_WAIT;
                        changed_q    <= accum_q;
                        frame_done_q <= 1'b1;
                        if (32'(accum_q) >= COUNT_THRESH) begin
                            alarm_q <= 1'b1;
                        end
                    end
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign alarm         = alarm_q;
    assign changed_count = changed_q;
    assign frame_done    = frame_done_q;

endmodule
